// File: rtl/axis_pattern_gen.sv
// AXI4-Stream video test-pattern source: colour bars, grid, gradient or solid fill,
// one 32-bit beat per pixel, frames of H_ACTIVE x V_ACTIVE with tuser/tlast framing.
module axis_pattern_gen #(
  parameter int H_ACTIVE = 480,
  parameter int V_ACTIVE = 272,
  parameter int GRID     = 16
) (
  input  logic        axis_aclk,
  input  logic        axis_aresetn,
  input  logic        gen_en,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic [31:0] axis_tdata,
  output logic        axis_tvalid,
  input  logic        axis_tready,
  output logic        axis_tuser,
  output logic        axis_tlast,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam logic [10:0] X_LAST    = 11'(H_ACTIVE - 1);
  localparam logic [10:0] Y_LAST    = 11'(V_ACTIVE - 1);
  localparam logic [10:0] BAR_LAST  = 11'(H_ACTIVE / 8 - 1);
  localparam logic [10:0] GRID_LAST = 11'(GRID - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_reg, state_next;
  logic [10:0] x_reg, x_next, y_reg, y_next;
  logic [10:0] bar_cnt_reg, bar_cnt_next;
  logic [2:0]  bar_idx_reg, bar_idx_next;
  logic [10:0] gx_reg, gx_next, gy_reg, gy_next;
  logic [1:0]  pat_reg, pat_next;
  logic [23:0] solid_reg, solid_next;
  logic [23:0] rgb_reg, rgb_next;
  logic        tvalid_reg, tvalid_next;
  logic        tuser_reg, tuser_next;
  logic        tlast_reg, tlast_next;
  logic        done_reg, done_next;
  logic [15:0] cnt_reg, cnt_next;

  logic        xfer, frame_end, load, step;
  logic [23:0] pix;

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_reg   <= IDLE;
      x_reg       <= '0;
      y_reg       <= '0;
      bar_cnt_reg <= '0;
      bar_idx_reg <= '0;
      gx_reg      <= '0;
      gy_reg      <= '0;
      pat_reg     <= '0;
      solid_reg   <= '0;
      rgb_reg     <= '0;
      tvalid_reg  <= 1'b0;
      tuser_reg   <= 1'b0;
      tlast_reg   <= 1'b0;
      done_reg    <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      bar_cnt_reg <= bar_cnt_next;
      bar_idx_reg <= bar_idx_next;
      gx_reg      <= gx_next;
      gy_reg      <= gy_next;
      pat_reg     <= pat_next;
      solid_reg   <= solid_next;
      rgb_reg     <= rgb_next;
      tvalid_reg  <= tvalid_next;
      tuser_reg   <= tuser_next;
      tlast_reg   <= tlast_next;
      done_reg    <= done_next;
      cnt_reg     <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    x_next       = x_reg;
    y_next       = y_reg;
    bar_cnt_next = bar_cnt_reg;
    bar_idx_next = bar_idx_reg;
    gx_next      = gx_reg;
    gy_next      = gy_reg;
    pat_next     = pat_reg;
    solid_next   = solid_reg;
    rgb_next     = rgb_reg;
    tvalid_next  = tvalid_reg;
    tuser_next   = tuser_reg;
    tlast_next   = tlast_reg;
    done_next    = 1'b0;
    cnt_next     = cnt_reg;
    load         = 1'b0;
    step         = 1'b0;
    pix          = 24'h0;

    xfer      = tvalid_reg & axis_tready;
    frame_end = xfer && (x_reg == X_LAST) && (y_reg == Y_LAST);

    case (state_reg)
      IDLE: begin
        if (gen_en) begin
          load       = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (frame_end) begin
          done_next = 1'b1;
          cnt_next  = cnt_reg + 16'd1;
          if (gen_en) begin
            load = 1'b1;
          end else begin
            state_next  = IDLE;
            x_next      = '0;
            y_next      = '0;
            rgb_next    = '0;
            tvalid_next = 1'b0;
            tuser_next  = 1'b0;
            tlast_next  = 1'b0;
          end
        end else if (xfer) begin
          step = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Coordinates and sub-counters describe the beat about to be presented
    if (load) begin
      x_next       = '0;
      y_next       = '0;
      bar_cnt_next = '0;
      bar_idx_next = '0;
      gx_next      = '0;
      gy_next      = '0;
      pat_next     = pattern_sel;
      solid_next   = solid_rgb;
    end else if (step) begin
      if (x_reg == X_LAST) begin
        x_next       = '0;
        y_next       = y_reg + 11'd1;
        bar_cnt_next = '0;
        bar_idx_next = '0;
        gx_next      = '0;
        gy_next      = (gy_reg == GRID_LAST) ? 11'd0 : gy_reg + 11'd1;
      end else begin
        x_next  = x_reg + 11'd1;
        gx_next = (gx_reg == GRID_LAST) ? 11'd0 : gx_reg + 11'd1;
        if (bar_cnt_reg == BAR_LAST) begin
          bar_cnt_next = '0;
          bar_idx_next = bar_idx_reg + 3'd1;
        end else begin
          bar_cnt_next = bar_cnt_reg + 11'd1;
        end
      end
    end

    // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0]
    case (pat_next)
      2'd0: pix = {{8{~bar_idx_next[1]}}, {8{~bar_idx_next[2]}}, {8{~bar_idx_next[0]}}};
      2'd1: if (gx_next == 11'd0 || gy_next == 11'd0 || x_next == X_LAST || y_next == Y_LAST)
              pix = 24'hFFFFFF;
      2'd2: pix = {3{x_next[7:0]}};
      default: pix = solid_next;
    endcase

    if (load || step) begin
      tvalid_next = 1'b1;
      tuser_next  = load;
      tlast_next  = (x_next == X_LAST);
      rgb_next    = pix;
    end
  end

  assign axis_tdata  = {8'h00, rgb_reg};
  assign axis_tvalid = tvalid_reg;
  assign axis_tuser  = tuser_reg;
  assign axis_tlast  = tlast_reg;
  assign frame_done  = done_reg;
  assign frame_cnt   = cnt_reg;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Randomized-handshake bench for axis_pattern_gen: a coordinate-level pixel model is
// compared against the stream every cycle, plus literal pixel expectations.
module tb_axis_pattern_gen;

  localparam int H  = 16;
  localparam int V  = 4;
  localparam int G  = 4;
  localparam int HW = 480;
  localparam int VW = 2;
  localparam int GW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aresetn = 1'b0;
  logic        gen_en = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [23:0] solid_rgb = 24'h0;
  logic        tready_fix = 1'b0;
  logic        rnd_mode = 1'b0;
  logic        rnd_bit = 1'b0;
  logic        tready;
  logic [31:0] tdata;
  logic        tvalid, tuser, tlast, frame_done;
  logic [15:0] frame_cnt;

  logic        aresetn_w = 1'b0;
  logic        gen_en_w = 1'b0;
  logic        tready_w = 1'b1;
  logic [31:0] tdata_w;
  logic        tvalid_w, tuser_w, tlast_w, frame_done_w;
  logic [15:0] frame_cnt_w;

  assign tready = rnd_mode ? rnd_bit : tready_fix;

  axis_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .GRID(G)) u_dut (
    .axis_aclk(clk), .axis_aresetn(aresetn), .gen_en(gen_en), .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb), .axis_tdata(tdata), .axis_tvalid(tvalid), .axis_tready(tready),
    .axis_tuser(tuser), .axis_tlast(tlast), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  axis_pattern_gen #(.H_ACTIVE(HW), .V_ACTIVE(VW), .GRID(GW)) u_wide (
    .axis_aclk(clk), .axis_aresetn(aresetn_w), .gen_en(gen_en_w), .pattern_sel(2'd2),
    .solid_rgb(24'h0), .axis_tdata(tdata_w), .axis_tvalid(tvalid_w), .axis_tready(tready_w),
    .axis_tuser(tuser_w), .axis_tlast(tlast_w), .frame_done(frame_done_w),
    .frame_cnt(frame_cnt_w)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_pix(int pat, logic [23:0] solid, int x, int y,
                                            int h, int v, int g);
    logic [23:0] rgb;
    logic [7:0]  lum;
    lum = 8'(x % 256);
    case (pat)
      0: case (x / (h / 8))
           0: rgb = 24'hFFFFFF;
           1: rgb = 24'hFFFF00;
           2: rgb = 24'h00FFFF;
           3: rgb = 24'h00FF00;
           4: rgb = 24'hFF00FF;
           5: rgb = 24'hFF0000;
           6: rgb = 24'h0000FF;
           default: rgb = 24'h000000;
         endcase
      1: rgb = (x % g == 0 || y % g == 0 || x == h - 1 || y == v - 1) ? 24'hFFFFFF : 24'h0;
      2: rgb = {lum, lum, lum};
      default: rgb = solid;
    endcase
    return {8'h00, rgb};
  endfunction

  // Reference model: which pixel must be on the bus, advanced by accepted beats
  bit          m_active = 0;
  bit          m_done = 0;
  int          m_x = 0, m_y = 0, m_pat = 0, m_cnt = 0;
  logic [23:0] m_solid = 24'h0;
  int          cyc = 0;
  int          done_seen = 0;
  logic [31:0] q_data[$];
  bit          q_user[$];
  bit          q_last[$];
  int          q_cyc[$];
  logic [31:0] w_data[$];

  always @(negedge clk) begin
    cyc++;
    if (!aresetn) begin
      check("rst_tvalid", 32'(tvalid), 32'd0);
      check("rst_tdata", tdata, 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      m_active = 0; m_done = 0; m_x = 0; m_y = 0; m_cnt = 0;
    end else begin
      check("tvalid", 32'(tvalid), 32'(m_active));
      check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
      check("frame_done", 32'(frame_done), 32'(m_done));
      if (frame_done) done_seen++;
      m_done = 0;
      if (m_active) begin
        check("tdata", tdata, model_pix(m_pat, m_solid, m_x, m_y, H, V, G));
        check("tuser", 32'(tuser), 32'(m_x == 0 && m_y == 0));
        check("tlast", 32'(tlast), 32'(m_x == H - 1));
        if (tready) begin
          q_data.push_back(tdata);
          q_user.push_back(tuser);
          q_last.push_back(tlast);
          q_cyc.push_back(cyc);
          if (m_x == H - 1 && m_y == V - 1) begin
            m_done = 1;
            m_cnt = (m_cnt + 1) % 65536;
            m_x = 0; m_y = 0;
            if (gen_en) begin
              m_pat = int'(pattern_sel); m_solid = solid_rgb;
            end else begin
              m_active = 0;
            end
          end else if (m_x == H - 1) begin
            m_x = 0; m_y++;
          end else begin
            m_x++;
          end
        end
      end else if (gen_en) begin
        m_active = 1; m_x = 0; m_y = 0;
        m_pat = int'(pattern_sel); m_solid = solid_rgb;
      end
    end
    if (aresetn_w && tvalid_w && tready_w) w_data.push_back(tdata_w);
  end

  always begin
    @(posedge clk);
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  task automatic clear_q();
    q_data.delete(); q_user.delete(); q_last.delete(); q_cyc.delete();
    done_seen = 0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0; gen_en = 1'b0; tready_fix = 1'b0; rnd_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1 aresetn = 1'b1;
    clear_q();
  endtask

  task automatic wait_beats(input int n, input int budget);
    int c = 0;
    while (q_data.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    check("beat_count_reached", 32'(q_data.size() >= n), 32'd1);
  endtask

  task automatic wait_first_valid(output int lat);
    lat = 0;
    while (!tvalid && lat < 10) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  logic [31:0] ref1[$];
  int          lat, n_last, n_user, n_bad;

  initial begin
    // Case 1: bars, tready=1, single frame
    do_reset();
    check("reset_tvalid", 32'(tvalid), 32'd0);
    gen_en = 1'b1; pattern_sel = 2'd0; tready_fix = 1'b1;
    wait_first_valid(lat);
    check("first_beat_latency", 32'(lat), 32'd1);
    gen_en = 1'b0;
    wait_beats(64, 200);
    repeat (3) @(posedge clk);
    #1;
    check("c1_idle_after", 32'(tvalid), 32'd0);
    check("c1_beat0", q_data[0], 32'h00FFFFFF);
    check("c1_beat1", q_data[1], 32'h00FFFFFF);
    check("c1_beat2", q_data[2], 32'h00FFFF00);
    check("c1_beat3", q_data[3], 32'h00FFFF00);
    check("c1_beat14", q_data[14], 32'h0);
    check("c1_beat15", q_data[15], 32'h0);
    n_last = 0; n_user = 0;
    foreach (q_last[i]) begin
      n_last += int'(q_last[i]);
      n_user += int'(q_user[i]);
    end
    check("c1_tlast_count", 32'(n_last), 32'd4);
    check("c1_tlast_63", 32'(q_last[63]), 32'd1);
    check("c1_tlast_47", 32'(q_last[47]), 32'd1);
    check("c1_tuser_count", 32'(n_user), 32'd1);
    check("c1_tuser_0", 32'(q_user[0]), 32'd1);
    check("c1_frame_done", 32'(done_seen), 32'd1);
    ref1 = q_data;
    $display("case1: %0d beats captured", q_data.size());

    // Case 2: random tready, same sequence
    do_reset();
    gen_en = 1'b1; pattern_sel = 2'd0; rnd_mode = 1'b1;
    wait_first_valid(lat);
    gen_en = 1'b0;
    wait_beats(64, 1000);
    repeat (3) @(posedge clk);
    #1;
    n_bad = 0;
    for (int i = 0; i < 64; i++) if (q_data[i] !== ref1[i]) n_bad++;
    check("c2_seq_vs_c1", 32'(n_bad), 32'd0);
    check("c2_frame_done", 32'(done_seen), 32'd1);
    $display("case2: %0d beats captured under random tready", q_data.size());

    // Case 3: continuous frames, pattern change mid-frame 2
    do_reset();
    gen_en = 1'b1; pattern_sel = 2'd0; tready_fix = 1'b1;
    wait_beats(96, 300);
    pattern_sel = 2'd2;
    wait_beats(140, 300);
    gen_en = 1'b0;
    wait_beats(192, 300);
    repeat (2) @(posedge clk);
    #1;
    check("c3_frame_cnt", 32'(frame_cnt), 32'd3);
    check("c3_no_bubble", 32'(q_cyc[191] - q_cyc[0]), 32'd191);
    check("c3_f2_beat2", q_data[66], 32'h00FFFF00);
    check("c3_f3_beat0", q_data[128], 32'h0);
    check("c3_f3_beat1", q_data[129], 32'h00010101);
    $display("case3: %0d beats over 3 frames", q_data.size());

    // Case 6: reset mid-frame while stalled (frame_cnt was 3)
    gen_en = 1'b1; pattern_sel = 2'd0; clear_q();
    wait_beats(30, 200);
    tready_fix = 1'b0;
    repeat (2) @(posedge clk);
    #2 aresetn = 1'b0;
    #1;
    check("c6_tvalid", 32'(tvalid), 32'd0);
    check("c6_tuser", 32'(tuser), 32'd0);
    check("c6_tlast", 32'(tlast), 32'd0);
    check("c6_tdata", tdata, 32'd0);
    check("c6_frame_cnt", 32'(frame_cnt), 32'd0);
    @(posedge clk);
    #1 aresetn = 1'b1;
    clear_q();
    tready_fix = 1'b1;
    wait_beats(1, 20);
    check("c6_first_tuser", 32'(q_user[0]), 32'd1);
    check("c6_first_data", q_data[0], 32'h00FFFFFF);
    gen_en = 1'b0;
    wait_beats(64, 200);
    $display("case6: restart after reset, %0d beats", q_data.size());

    // Case 4: gen_en dropped at beat 20, solid fill
    do_reset();
    gen_en = 1'b1; pattern_sel = 2'd3; solid_rgb = 24'h123456; rnd_mode = 1'b1;
    wait_beats(21, 200);
    gen_en = 1'b0;
    solid_rgb = 24'hABCDEF;
    wait_beats(64, 1000);
    repeat (4) @(posedge clk);
    #1;
    check("c4_idle", 32'(tvalid), 32'd0);
    check("c4_beats", 32'(q_data.size()), 32'd64);
    check("c4_frame_done", 32'(done_seen), 32'd1);
    n_bad = 0;
    foreach (q_data[i]) if (q_data[i] !== 32'h00123456) n_bad++;
    check("c4_solid_all", 32'(n_bad), 32'd0);
    $display("case4: %0d beats delivered after gen_en drop", q_data.size());

    // Case 5: grid
    do_reset();
    gen_en = 1'b1; pattern_sel = 2'd1; rnd_mode = 1'b1;
    wait_first_valid(lat);
    gen_en = 1'b0;
    wait_beats(64, 1000);
    check("c5_px_0_0", q_data[0], 32'h00FFFFFF);
    check("c5_px_4_1", q_data[20], 32'h00FFFFFF);
    check("c5_px_15_2", q_data[47], 32'h00FFFFFF);
    check("c5_px_7_3", q_data[55], 32'h00FFFFFF);
    check("c5_px_1_1", q_data[17], 32'h0);
    $display("case5: grid frame %0d beats", q_data.size());

    // Case 5b: gradient on a 480-wide raster
    repeat (2) @(posedge clk);
    #1 aresetn_w = 1'b1;
    gen_en_w = 1'b1;
    @(posedge clk);
    #1 gen_en_w = 1'b0;
    begin
      int c = 0;
      while (w_data.size() < HW * VW && c < 2000) begin
        @(posedge clk);
        c++;
      end
    end
    #1;
    check("c5_wide_beats", 32'(w_data.size()), 32'(HW * VW));
    check("c5_grad_x300", w_data[300], 32'h002C2C2C);
    n_bad = 0;
    foreach (w_data[i]) if (w_data[i] !== model_pix(2, 24'h0, i % HW, i / HW, HW, VW, GW)) n_bad++;
    check("c5_grad_all", 32'(n_bad), 32'd0);
    $display("case5b: gradient frame %0d beats", w_data.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
